writeback_stage: RTL and testbench

Final stage of the five-stage RV32I pipeline, directly downstream of `mem_stage`. It captures the memory-stage result, extracts and extends load data by `funct3` and byte offset, and issues a single-cycle register-file write. It exposes a forwarding tap for the hazard unit and honours the pipeline stall and flush protocol.

---
 rtl/writeback_stage_pkg.sv | 35 +++
 rtl/writeback_stage_load_extend.sv | 40 ++++
 rtl/writeback_stage.sv | 143 ++++++++++++++
 tb/tb_writeback_stage.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_stage_pkg.sv
// Shared definitions for the writeback stage: one-hot opcode layout,
// load funct3 codes and FSM state type. The opcode indices and funct3 codes
// match mem_stage so both stages decode the same bus.
package writeback_stage_pkg;

  // One-hot opcode bus layout shared with the upstream stages.
  localparam int OPCODE_WIDTH = 11;

  localparam int RTYPE      = 0;
  localparam int ITYPE      = 1;
  localparam int LOAD_WORD  = 2;
  localparam int STORE_WORD = 3;
  localparam int BRANCH     = 4;
  localparam int JAL        = 5;
  localparam int JALR       = 6;
  localparam int LUI        = 7;
  localparam int AUIPC      = 8;
  localparam int SYSTEM     = 9;
  localparam int FENCE      = 10;

  // RV32I load funct3 encodings.
  localparam logic [2:0] FUNCT_LB  = 3'b000;
  localparam logic [2:0] FUNCT_LH  = 3'b001;
  localparam logic [2:0] FUNCT_LW  = 3'b010;
  localparam logic [2:0] FUNCT_LBU = 3'b100;
  localparam logic [2:0] FUNCT_LHU = 3'b101;

  // Writeback holding-register state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WRITE = 2'd1,
    HOLD  = 2'd2
  } wb_state_e;

endpackage

// File: rtl/writeback_stage_load_extend.sv
// load_extend: selects the addressed byte/half of an aligned memory word
// and sign- or zero-extends it according to funct3. Purely combinational
// so mem_stage can share it later. Requires DWIDTH >= 32.
module load_extend
  import writeback_stage_pkg::*;
#(
  parameter int DWIDTH      = 32,
  parameter int FUNCT_WIDTH = 3
) (
  input  logic [FUNCT_WIDTH-1:0] funct3,
  input  logic [1:0]             lsb,
  input  logic [DWIDTH-1:0]      word,
  output logic [DWIDTH-1:0]      value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Byte lane picked by the full offset, half lane by offset bit 1 only.
  always_comb begin
    byte_sel = word[{lsb, 3'b000} +: 8];
    half_sel = word[{lsb[1], 4'b0000} +: 16];
  end

  // Extend the selected lane; unknown funct3 codes pass the whole word.
  always_comb begin
    // NOTE: value gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    value = word;
    case (funct3)
      FUNCT_WIDTH'(FUNCT_LB):  value = {{(DWIDTH-8){byte_sel[7]}}, byte_sel};
      FUNCT_WIDTH'(FUNCT_LBU): value = {{(DWIDTH-8){1'b0}}, byte_sel};
      FUNCT_WIDTH'(FUNCT_LH):  value = {{(DWIDTH-16){half_sel[15]}}, half_sel};
      FUNCT_WIDTH'(FUNCT_LHU): value = {{(DWIDTH-16){1'b0}}, half_sel};
      FUNCT_WIDTH'(FUNCT_LW):  value = word;
      default:                 value = word;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: last stage of the RV32I pipeline. Holds one entry from
// mem_stage, extends load data, and issues a single-cycle register-file
// write. Provides a forwarding tap and obeys the stall/flush protocol.
// Optional feature: define WB_INSTRET_EN to add the 64-bit retired-entry
// counter and the wb_o_instret port.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int DWIDTH      = 32,
  parameter int AWIDTH      = 5,
  parameter int FUNCT_WIDTH = 3
) (
  input  logic                    wb_clk,
  input  logic                    wb_rst,
  input  logic                    wb_i_ce,
  input  logic                    wb_i_stall,
  input  logic                    wb_i_flush,
  input  logic [OPCODE_WIDTH-1:0] wb_i_opcode,
  input  logic [FUNCT_WIDTH-1:0]  wb_i_funct3,
  input  logic [1:0]              wb_i_addr_lsb,
  input  logic [DWIDTH-1:0]       wb_i_load_data,
  input  logic [AWIDTH-1:0]       wb_i_rd_addr,
  input  logic [DWIDTH-1:0]       wb_i_rd_data,
  input  logic                    wb_i_rd_we,
  output logic                    wb_o_stall,
  output logic                    wb_o_rd_we,
  output logic [AWIDTH-1:0]       wb_o_rd_addr,
  output logic [DWIDTH-1:0]       wb_o_rd_data,
  output logic                    wb_o_fwd_valid,
  output logic [AWIDTH-1:0]       wb_o_fwd_addr,
  output logic [DWIDTH-1:0]       wb_o_fwd_data
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]             wb_o_instret
`endif
);

  wb_state_e               state;
  logic [OPCODE_WIDTH-1:0] opcode_q;
  logic [FUNCT_WIDTH-1:0]  funct3_q;
  logic [1:0]              lsb_q;
  logic [DWIDTH-1:0]       load_data_q;
  logic [AWIDTH-1:0]       rd_addr_q;
  logic [DWIDTH-1:0]       rd_data_q;
  logic                    rd_we_q;

  logic                    capture;
  logic                    writes_reg;
  logic [DWIDTH-1:0]       load_value;
  logic [DWIDTH-1:0]       wb_value;

  // Only the LOAD bit of the held opcode steers the datapath; the rest is
  // kept for debug visibility and folded here to mark it intentionally idle.
  logic unused_opcode_bits;
  assign unused_opcode_bits = ^opcode_q;

  // Back-pressure only while an entry is actually held.
  assign wb_o_stall = wb_i_stall & (state != EMPTY);

  // A deferred entry has priority over a new one: in HOLD nothing is taken,
  // even in the release cycle, so the held write is never overwritten.
  assign capture = wb_i_ce & ~wb_o_stall & ~wb_i_flush & (state != HOLD);

  // State and held entry fields.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      // NOTE: the held fields are reset (not just the state) because they
      // drive wb_o_rd_addr/wb_o_rd_data directly and must read 0 after reset.
      state       <= EMPTY;
      opcode_q    <= '0;
      funct3_q    <= '0;
      lsb_q       <= '0;
      load_data_q <= '0;
      rd_addr_q   <= '0;
      rd_data_q   <= '0;
      rd_we_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      if (wb_i_flush) begin
        state <= EMPTY;
      end else begin
        case (state)
          EMPTY, WRITE: begin
            if (capture) state <= wb_i_stall ? HOLD : WRITE;
            else         state <= EMPTY;
          end
          HOLD: begin
            if (!wb_i_stall) state <= WRITE;
          end
          default: state <= EMPTY;
        endcase
      end

      if (capture) begin
        opcode_q    <= wb_i_opcode;
        funct3_q    <= wb_i_funct3;
        lsb_q       <= wb_i_addr_lsb;
        load_data_q <= wb_i_load_data;
        rd_addr_q   <= wb_i_rd_addr;
        rd_data_q   <= wb_i_rd_data;
        rd_we_q     <= wb_i_rd_we;
      end
    end
  end

  load_extend #(
    .DWIDTH      (DWIDTH),
    .FUNCT_WIDTH (FUNCT_WIDTH)
  ) u_load_extend (
    .funct3 (funct3_q),
    .lsb    (lsb_q),
    .word   (load_data_q),
    .value  (load_value)
  );

  // Writes to x0 are architecturally discarded, so they never strobe.
  assign writes_reg = rd_we_q & (rd_addr_q != '0);
  assign wb_value   = opcode_q[LOAD_WORD] ? load_value : rd_data_q;

  // Flush cancels the strobe in its own cycle; this is the only input that
  // reaches the write port combinationally.
  assign wb_o_rd_we   = (state == WRITE) & writes_reg & ~wb_i_flush;
  assign wb_o_rd_addr = rd_addr_q;
  assign wb_o_rd_data = wb_value;

  // Forwarding is offered as soon as the entry is held, including in HOLD.
  assign wb_o_fwd_valid = (state != EMPTY) & writes_reg;
  assign wb_o_fwd_addr  = rd_addr_q;
  assign wb_o_fwd_data  = wb_value;

`ifdef WB_INSTRET_EN
  // Count every entry that completes its WRITE cycle, stores included.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      wb_o_instret <= 64'd0;
    end else if ((state == WRITE) && !wb_i_flush) begin
      wb_o_instret <= wb_o_instret + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed cases with literal
// expectations plus randomized traffic compared every cycle against a
// behavioural model of the one-entry writeback buffer.
module tb_writeback_stage;
  import writeback_stage_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int FW = 3;

  logic                    wb_clk = 1'b0;
  logic                    wb_rst;
  logic                    wb_i_ce;
  logic                    wb_i_stall;
  logic                    wb_i_flush;
  logic [OPCODE_WIDTH-1:0] wb_i_opcode;
  logic [FW-1:0]           wb_i_funct3;
  logic [1:0]              wb_i_addr_lsb;
  logic [DW-1:0]           wb_i_load_data;
  logic [AW-1:0]           wb_i_rd_addr;
  logic [DW-1:0]           wb_i_rd_data;
  logic                    wb_i_rd_we;
  logic                    wb_o_stall;
  logic                    wb_o_rd_we;
  logic [AW-1:0]           wb_o_rd_addr;
  logic [DW-1:0]           wb_o_rd_data;
  logic                    wb_o_fwd_valid;
  logic [AW-1:0]           wb_o_fwd_addr;
  logic [DW-1:0]           wb_o_fwd_data;
`ifdef WB_INSTRET_EN
  logic [63:0]             wb_o_instret;
`endif

  writeback_stage #(.DWIDTH(DW), .AWIDTH(AW), .FUNCT_WIDTH(FW)) dut (
    .wb_clk         (wb_clk),
    .wb_rst         (wb_rst),
    .wb_i_ce        (wb_i_ce),
    .wb_i_stall     (wb_i_stall),
    .wb_i_flush     (wb_i_flush),
    .wb_i_opcode    (wb_i_opcode),
    .wb_i_funct3    (wb_i_funct3),
    .wb_i_addr_lsb  (wb_i_addr_lsb),
    .wb_i_load_data (wb_i_load_data),
    .wb_i_rd_addr   (wb_i_rd_addr),
    .wb_i_rd_data   (wb_i_rd_data),
    .wb_i_rd_we     (wb_i_rd_we),
    .wb_o_stall     (wb_o_stall),
    .wb_o_rd_we     (wb_o_rd_we),
    .wb_o_rd_addr   (wb_o_rd_addr),
    .wb_o_rd_data   (wb_o_rd_data),
    .wb_o_fwd_valid (wb_o_fwd_valid),
    .wb_o_fwd_addr  (wb_o_fwd_addr),
    .wb_o_fwd_data  (wb_o_fwd_data)
`ifdef WB_INSTRET_EN
    ,
    .wb_o_instret   (wb_o_instret)
`endif
  );

  always #5 wb_clk = ~wb_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The stage is a one-slot buffer: an entry is either absent, due to be
  // written this cycle, or parked until the stall clears.
  bit          m_have;
  bit          m_due;
  bit          m_load;
  bit [2:0]    m_f3;
  bit [1:0]    m_lsb;
  bit [31:0]   m_word;
  bit [4:0]    m_rd;
  bit [31:0]   m_data;
  bit          m_we;
  bit [63:0]   m_instret;

  // Load extraction by shift/mask arithmetic.
  function automatic bit [31:0] ref_load(input bit [2:0] f3, input bit [1:0] lsb, input bit [31:0] word);
    longint v;
    case (f3)
      3'b000: begin v = longint'((word >> (8 * lsb)) & 32'hFF); if (v >= 128) v -= 256; end
      3'b100: v = longint'((word >> (8 * lsb)) & 32'hFF);
      3'b001: begin v = longint'((word >> (16 * (lsb / 2))) & 32'hFFFF); if (v >= 32768) v -= 65536; end
      3'b101: v = longint'((word >> (16 * (lsb / 2))) & 32'hFFFF);
      default: v = longint'(word);
    endcase
    return v[31:0];
  endfunction

  function automatic bit [31:0] model_value();
    return m_load ? ref_load(m_f3, m_lsb, m_word) : m_data;
  endfunction

  task automatic compare();
    bit wr;
    wr = m_we && (m_rd != 0);
    check("stall_out", wb_o_stall, wb_i_stall & m_have);
    check("rd_we", wb_o_rd_we, m_have & m_due & wr & ~wb_i_flush);
    check("fwd_valid", wb_o_fwd_valid, m_have & wr);
    if (m_have && wr) begin
      check("rd_addr", wb_o_rd_addr, m_rd);
      check("rd_data", wb_o_rd_data, model_value());
      check("fwd_addr", wb_o_fwd_addr, m_rd);
      check("fwd_data", wb_o_fwd_data, model_value());
    end
`ifdef WB_INSTRET_EN
    check("instret", wb_o_instret, m_instret);
`endif
  endtask

  task automatic model_update();
    bit parked;
    bit stalled_out;
    if (m_have && m_due && !wb_i_flush) m_instret++;
    if (wb_i_flush) begin
      m_have = 0;
    end else begin
      parked      = m_have && !m_due;
      stalled_out = wb_i_stall && m_have;
      if (parked) begin
        // A parked entry is never displaced; it becomes due once stall drops.
        if (!wb_i_stall) m_due = 1;
      end else if (wb_i_ce && !stalled_out) begin
        m_have = 1;
        m_due  = !wb_i_stall;
        m_load = wb_i_opcode[LOAD_WORD];
        m_f3   = wb_i_funct3;
        m_lsb  = wb_i_addr_lsb;
        m_word = wb_i_load_data;
        m_rd   = wb_i_rd_addr;
        m_data = wb_i_rd_data;
        m_we   = wb_i_rd_we;
      end else begin
        m_have = 0;
      end
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    @(negedge wb_clk);
    compare();
    @(posedge wb_clk);
    model_update();
    #1;
  endtask

  task automatic drive(input bit ce, input bit stall, input bit flush, input int opc,
                       input bit [2:0] f3, input bit [1:0] lsb, input bit [31:0] word,
                       input bit [4:0] rd, input bit [31:0] data, input bit we);
    wb_i_ce        = ce;
    wb_i_stall     = stall;
    wb_i_flush     = flush;
    wb_i_opcode    = '0;
    wb_i_opcode[opc] = 1'b1;
    wb_i_funct3    = f3;
    wb_i_addr_lsb  = lsb;
    wb_i_load_data = word;
    wb_i_rd_addr   = rd;
    wb_i_rd_data   = data;
    wb_i_rd_we     = we;
  endtask

  task automatic idle(input bit stall);
    drive(0, stall, 0, RTYPE, 3'd0, 2'd0, 32'd0, 5'd0, 32'd0, 0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
  task automatic do_reset();
    wb_rst = 1'b1;
    #2;
    check("reset_rd_we", wb_o_rd_we, 0);
    check("reset_fwd_valid", wb_o_fwd_valid, 0);
    check("reset_stall", wb_o_stall, 0);
    check("reset_rd_addr", wb_o_rd_addr, 0);
    check("reset_rd_data", wb_o_rd_data, 0);
`ifdef WB_INSTRET_EN
    check("reset_instret", wb_o_instret, 0);
`endif
    m_have    = 0;
    m_due     = 0;
    m_instret = 0;
    @(posedge wb_clk);
    #1;
    wb_rst = 1'b0;
  endtask

  typedef struct {
    bit [2:0]  f3;
    bit [1:0]  lsb;
    bit [31:0] exp;
  } load_case_t;

  initial begin
    load_case_t lc [5];
    lc[0] = '{3'b000, 2'd0, 32'hFFFFFFBE};
    lc[1] = '{3'b100, 2'd1, 32'h000000BA};
    lc[2] = '{3'b001, 2'd2, 32'hFFFFCAFE};
    lc[3] = '{3'b101, 2'd0, 32'h0000BABE};
    lc[4] = '{3'b010, 2'd3, 32'hCAFEBABE};

    idle(0);
    do_reset();

    // RTYPE entry: one-cycle write, then strobe drops.
    drive(1, 0, 0, RTYPE, 3'd0, 2'd0, 32'd0, 5'd5, 32'h12345678, 1);
    step();
    idle(0);
    #2;
    check("rtype_we", wb_o_rd_we, 1);
    check("rtype_addr", wb_o_rd_addr, 5);
    check("rtype_data", wb_o_rd_data, 32'h12345678);
    step();
    #2;
    check("rtype_we_after", wb_o_rd_we, 0);
    step();

    // Loads of 0xCAFEBABE: pin the model and the DUT to literal values.
    foreach (lc[i]) begin
      check("load_model", ref_load(lc[i].f3, lc[i].lsb, 32'hCAFEBABE), lc[i].exp);
      drive(1, 0, 0, LOAD_WORD, lc[i].f3, lc[i].lsb, 32'hCAFEBABE, 5'd3, 32'h0, 1);
      step();
      idle(0);
      #2;
      check("load_data", wb_o_rd_data, lc[i].exp);
      step();
    end

    // Three-cycle stall with a parked entry: exactly one write after release.
    drive(1, 1, 0, RTYPE, 3'd0, 2'd0, 32'd0, 5'd7, 32'hA5A5_0001, 1);
    step();
    for (int i = 0; i < 3; i++) begin
      idle(1);
      #2;
      check("hold_stall", wb_o_stall, 1);
      check("hold_fwd", wb_o_fwd_valid, 1);
      check("hold_no_write", wb_o_rd_we, 0);
      step();
    end
    idle(0);
    #2;
    check("release_no_write", wb_o_rd_we, 0);
    step();
    #2;
    check("release_write", wb_o_rd_we, 1);
    step();
    #2;
    check("release_single", wb_o_rd_we, 0);
    step();

    // Destination x0: no strobe, no forwarding.
    drive(1, 0, 0, ITYPE, 3'd0, 2'd0, 32'd0, 5'd0, 32'hDEADBEEF, 1);
    step();
    idle(0);
    #2;
    check("x0_we", wb_o_rd_we, 0);
    check("x0_fwd", wb_o_fwd_valid, 0);
    step();

    // Flush during HOLD with a simultaneous offer: both dropped.
    drive(1, 1, 0, RTYPE, 3'd0, 2'd0, 32'd0, 5'd9, 32'h0000_0099, 1);
    step();
    drive(1, 1, 1, RTYPE, 3'd0, 2'd0, 32'd0, 5'd10, 32'h0000_0010, 1);
    #2;
    check("flush_we", wb_o_rd_we, 0);
    step();
    idle(1);
    #2;
    check("flush_empty_stall", wb_o_stall, 0);
    check("flush_empty_fwd", wb_o_fwd_valid, 0);
    step();
    idle(0);
    step();
    #2;
    check("flush_no_late_write", wb_o_rd_we, 0);
    step();

    // Reset while an entry is parked: discarded, never written.
    drive(1, 1, 0, RTYPE, 3'd0, 2'd0, 32'd0, 5'd11, 32'h0000_0011, 1);
    step();
    idle(1);
    step();
    do_reset();
    idle(0);
    step();
    #2;
    check("rst_hold_no_write", wb_o_rd_we, 0);
    step();

`ifdef WB_INSTRET_EN
    // Four entries: one store, one flushed in its write cycle -> count of 3.
    drive(1, 0, 0, RTYPE, 3'd0, 2'd0, 32'd0, 5'd1, 32'h1, 1);
    step();
    drive(1, 0, 0, STORE_WORD, 3'd2, 2'd0, 32'd0, 5'd0, 32'h2, 0);
    step();
    drive(1, 0, 0, RTYPE, 3'd0, 2'd0, 32'd0, 5'd2, 32'h3, 1);
    step();
    drive(1, 0, 0, RTYPE, 3'd0, 2'd0, 32'd0, 5'd3, 32'h4, 1);
    step();
    drive(0, 0, 1, RTYPE, 3'd0, 2'd0, 32'd0, 5'd0, 32'h0, 0);
    step();
    idle(0);
    step();
    #2;
    check("instret_three", wb_o_instret, 64'd3);
    do_reset();
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int  opc;
      bit [4:0] rd;
      opc = ($urandom_range(0, 1) == 1) ? LOAD_WORD : $urandom_range(0, OPCODE_WIDTH - 1);
      rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0,
            opc, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom,
            rd, $urandom, $urandom_range(0, 4) != 0);
      step();
    end

    idle(0);
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
